// File: rtl/cache_fill_writer.sv
// cache_fill_writer: picks a victim way on a miss and fills its line word by word from memory
module cache_fill_writer #(
  parameter int WAYS       = 8,
  parameter int LINE_WORDS = 8,
  parameter int DATA_W     = 16
) (
  input  logic                          Clock,
  input  logic                          Reset_H,
  input  logic                          Miss_H,
  input  logic [WAYS-1:0]               Valid_In,
  input  logic [DATA_W-1:0]             MemData_In,
  input  logic                          MemAck_H,
  output logic                          MemReq_H,
  output logic [$clog2(LINE_WORDS)-1:0] WordIndex_Out,
  output logic [WAYS-1:0]               WayWrite_H,
  output logic [DATA_W-1:0]             DataOut,
  output logic                          Busy_H,
  output logic                          FillDone_H
);
  localparam int WW = $clog2(LINE_WORDS);
  localparam int RW = $clog2(WAYS);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]      state;
  logic [WAYS-1:0] victim, first_free, rr_hot, pick;
  logic [RW-1:0]   rr;
  logic [WW-1:0]   word;
  logic            used_rr, any_free, last_word;
  assign rr_hot    = WAYS'(1) << rr;
  assign pick      = any_free ? first_free : rr_hot;
  assign last_word = word == WW'(LINE_WORDS - 1);
  // lowest-index invalid way; any_free low means the set is full and RR decides
  always_comb begin
    first_free = '0;
    any_free   = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      first_free[i] = !Valid_In[i] && !any_free;
      any_free      = any_free || !Valid_In[i];
    end
  end
  // fill sequencer: victim latch, word counter, write data register and RR advance
  always_ff @(posedge Clock or posedge Reset_H)
    if (Reset_H) begin
      state   <= IDLE;
      victim  <= '0;
      rr      <= '0;
      used_rr <= 1'b0;
      word    <= '0;
      DataOut <= '0;
    end else case (state)
      IDLE: if (Miss_H) begin
        victim  <= pick;
        used_rr <= !any_free;
        word    <= '0;
        state   <= REQ;
      end
      REQ: if (MemAck_H) begin
        DataOut <= MemData_In;
        state   <= WRITE;
      end
      WRITE: begin
        word  <= last_word ? word : word + WW'(1);
        state <= last_word ? DONE : REQ;
      end
      default: begin
        rr      <= used_rr ? ((rr == RW'(WAYS - 1)) ? '0 : rr + RW'(1)) : rr;
        used_rr <= 1'b0;
        state   <= IDLE;
      end
    endcase
  assign MemReq_H      = state == REQ;
  assign WayWrite_H    = (state == WRITE) ? victim : '0;
  assign Busy_H        = state != IDLE;
  assign FillDone_H    = state == DONE;
  assign WordIndex_Out = word;
endmodule

// File: tb/tb_cache_fill_writer.sv
// tb_cache_fill_writer: directed and randomized fills checked against a behavioural victim/latency model
module tb_cache_fill_writer;
  localparam int WAYS = 8;
  localparam int LW   = 8;
  logic        clk = 1'b0, rst = 1'b1, miss = 1'b0, ack = 1'b0;
  logic [7:0]  valid = '0;
  logic [15:0] mdata = '0;
  logic        mem_req, busy, done;
  logic [2:0]  widx;
  logic [7:0]  way_we;
  logic [15:0] dout;
  int          checks = 0, errors = 0, rr = 0;
  logic [15:0] last_data = '0;

  cache_fill_writer #(.WAYS(WAYS), .LINE_WORDS(LW), .DATA_W(16)) dut (
    .Clock(clk), .Reset_H(rst), .Miss_H(miss), .Valid_In(valid),
    .MemData_In(mdata), .MemAck_H(ack), .MemReq_H(mem_req),
    .WordIndex_Out(widx), .WayWrite_H(way_we), .DataOut(dout),
    .Busy_H(busy), .FillDone_H(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_quiet(input string tag);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_we"}, way_we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_data"}, dout, last_data);
  endtask

  // one whole fill as seen from the memory side; rnd adds random waits, stray acks and Valid_In churn
  task automatic fill(input logic [7:0] v, input int dly, input bit rnd, input bit hold,
                      input int abort_w, input bit seq);
    logic [7:0]  exp_way;
    logic [15:0] d;
    bit          used;
    int          free, cnt, lat, dw;
    free = -1;
    for (int i = WAYS - 1; i >= 0; i--) if (!v[i]) free = i;
    used    = free < 0;
    exp_way = 8'(1) << (used ? rr : free);
    valid = v; miss = 1'b1; ack = 1'b0; d = '0;
    cnt = 1; lat = 2 * LW + 2;
    step(); cnt++;
    if (!hold) miss = 1'b0;
    if (rnd) valid = 8'($urandom);
    for (int w = 0; w < LW; w++) begin
      dw = rnd ? int'($urandom_range(0, 3)) : dly;
      lat += dw;
      for (int k = 0; k <= dw; k++) begin
        chk("req", mem_req, 1);
        chk("idx_req", widx, w);
        chk("nowrite_req", way_we, 0);
        chk("hold_data", dout, last_data);
        chk("busy", busy, 1);
        if (w == abort_w && k == 0) begin
          #2 rst = 1'b1;
          #1;
          chk("abort_req", mem_req, 0);
          chk("abort_we", way_we, 0);
          chk("abort_busy", busy, 0);
          chk("abort_idx", widx, 0);
          step();
          chk("abort_nodone", done, 0);
          rst = 1'b0; miss = 1'b0; ack = 1'b0; last_data = '0;
          return;
        end
        ack   = k == dw;
        d     = seq ? 16'(16'hA000 + w) : 16'($urandom);
        mdata = d;
        step(); cnt++;
      end
      last_data = d;
      chk("write_way", way_we, exp_way);
      chk("write_data", dout, d);
      chk("idx_write", widx, w);
      chk("req_low", mem_req, 0);
      ack   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      mdata = 16'($urandom);
      step(); cnt++;
    end
    chk("done", done, 1);
    chk("latency", cnt, lat);
    chk("nowrite_done", way_we, 0);
    chk("done_data", dout, last_data);
    if (used) rr = (rr + 1) % WAYS;
    step();
    ack = 1'b0;
    idle_quiet("after_fill");
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      idle_quiet("reset");
      chk("reset_idx", widx, 0);
      step();
    end
    fill(8'hF7, 0, 0, 0, -1, 1);
    fill(8'hFF, 0, 0, 0, 4, 0);
    for (int n = 0; n < 9; n++) begin
      if (n == 4) fill(8'hFE, 0, 0, 0, -1, 0);
      fill(8'hFF, 0, 0, 0, -1, 0);
    end
    fill(8'hFF, 5, 0, 0, -1, 0);
    ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mdata = 16'($urandom);
      step();
      idle_quiet("idle_ack");
    end
    fill(8'($urandom), 0, 1, 1, -1, 0);
    fill(8'hFF, 0, 1, 0, -1, 0);
    for (int n = 0; n < 15; n++)
      fill(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom), 0, 1, 0, -1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
